// File: rtl/dsp48a1_mac_issuer.sv
// dsp48a1_mac_issuer
//   Drives one DSP48A1 slice through a signed multiply-accumulate job.
//   A job command sets the number of terms and the accumulate sign. Operand
//   pairs are then streamed into the slice one term per cycle. Each term gets
//   an OPMODE, delayed OP_SKEW cycles so that it reaches the post-adder
//   together with its product. The slice P is captured LAT cycles after the
//   last term is presented, and the captured value is held on the result port.
//   Optional feature macro: MAC_SAT_EN. When it is defined, the result is
//   clamped to a signed SAT_W range. This requires SAT_W < P_W.
//   Assumes LAT >= 1 and OP_SKEW >= 1.
module dsp48a1_mac_issuer #(
   parameter int A_W     = 18,
   parameter int P_W     = 48,
   parameter int CNT_W   = 16,
   parameter int LAT     = 4,
   parameter int OP_SKEW = 2,
   parameter int SAT_W   = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [CNT_W-1:0] start_len,
   input  logic             start_sub,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [A_W-1:0]   op_a,
   input  logic [A_W-1:0]   op_b,
   output logic [A_W-1:0]   dsp_a,
   output logic [A_W-1:0]   dsp_b,
   output logic [7:0]       dsp_opmode,
   output logic             dsp_ce,
   output logic             dsp_rst,
   input  logic [P_W-1:0]   dsp_p,
   input  logic             dsp_carryout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [P_W-1:0]   res_data,
   output logic             res_carry,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam int DW   = $clog2(LAT + 1);
   localparam int HI_W = P_W - SAT_W + 1;

`ifdef MAC_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   logic [1:0]       state;
   logic [CNT_W-1:0] term_cnt;
   logic [DW-1:0]    drain_cnt;
   logic             sub_q;
   logic             first_q;
   logic             rst_q;
   logic [7:0]       opm_t;
   logic [7:0]       skew [OP_SKEW];
   logic             op_fire;
   logic             start_fire;
   logic [7:0]       opm_first;
   logic [7:0]       opm_cont;
   logic [HI_W-1:0]  sat_hi;
   logic             sat_hit;
   logic [P_W-1:0]   res_next;
   logic             carry_next;

   assign start_ready = (state == S_IDLE);
   assign op_ready    = (state == S_ISSUE);
   assign dsp_ce      = (state == S_ISSUE) || (state == S_DRAIN);
   assign res_valid   = (state == S_HOLD);
   assign busy        = (state != S_IDLE);
   assign op_fire     = (state == S_ISSUE) && op_valid;
   assign start_fire  = (state == S_IDLE) && start_valid;
   assign dsp_opmode  = skew[OP_SKEW-1];
   // The slice registers are reset for one extra edge after the issuer leaves reset.
   assign dsp_rst     = rst | rst_q;

   // Opmode for the first term: Z=0, X=M. Later terms and bubbles use Z=P, X=M.
   assign opm_first = {sub_q, 3'b000, 2'b00, 2'b01};
   assign opm_cont  = {sub_q, 3'b000, 2'b10, 2'b01};

   // Result selection: pass the slice P through, or clamp it when saturation is built in.
   always_comb begin
      sat_hi     = dsp_p[P_W-1:SAT_W-1];
      sat_hit    = SAT_ON && !((&sat_hi) || !(|sat_hi));
      res_next   = dsp_p;
      carry_next = dsp_carryout;
      if (sat_hit) begin
         carry_next = 1'b1;
         res_next   = dsp_p[P_W-1] ? {{HI_W{1'b1}}, {(SAT_W-1){1'b0}}}
                                   : {{HI_W{1'b0}}, {(SAT_W-1){1'b1}}};
      end
   end

   // Delayed copy of rst. It stretches dsp_rst by one cycle.
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // Job control: command latch, term counting, drain timing and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         term_cnt  <= '0;
         drain_cnt <= '0;
         sub_q     <= 1'b0;
         first_q   <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  sub_q   <= start_sub;
                  first_q <= 1'b1;
                  if (start_len == '0) begin
                     state     <= S_HOLD;
                     res_data  <= '0;
                     res_carry <= 1'b0;
                  end else begin
                     state    <= S_ISSUE;
                     term_cnt <= start_len;
                  end
               end
            end
            S_ISSUE: begin
               if (op_valid) begin
                  first_q  <= 1'b0;
                  term_cnt <= term_cnt - CNT_W'(1);
                  if (term_cnt == CNT_W'(1)) begin
                     state     <= S_DRAIN;
                     drain_cnt <= DW'(LAT);
                  end
               end
            end
            S_DRAIN: begin
               // The last term is on dsp_a/dsp_b in the first DRAIN cycle.
               // dsp_p includes it LAT cycles later.
               if (drain_cnt == '0) begin
                  state     <= S_HOLD;
                  res_data  <= res_next;
                  res_carry <= carry_next;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            S_HOLD: begin
               if (res_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Operand presentation. Each cycle carries either an accepted pair or a zero bubble, plus that cycle's term opmode.
   always_ff @(posedge clk) begin
      if (rst) begin
         dsp_a <= '0;
         dsp_b <= '0;
         opm_t <= '0;
      end else if (op_fire) begin
         dsp_a <= op_a;
         dsp_b <= op_b;
         opm_t <= first_q ? opm_first : opm_cont;
      end else begin
         dsp_a <= '0;
         dsp_b <= '0;
         opm_t <= (dsp_ce && !first_q) ? opm_cont : 8'h00;
      end
   end

   // Opmode skew line. It advances with the slice clock enable and is cleared at job start.
   always_ff @(posedge clk) begin
      if (rst || start_fire) begin
         for (int unsigned i = 0; i < OP_SKEW; i++) skew[i] <= '0;
      end else if (dsp_ce) begin
         skew[0] <= opm_t;
         for (int unsigned i = 1; i < OP_SKEW; i++) skew[i] <= skew[i-1];
      end
   end

endmodule
